// File: rtl/ghr_ckpt.sv
// ghr_ckpt: speculative global branch history with per-branch checkpoints.
//
// Each predicted conditional branch pushes the pre-update history into a
// circular checkpoint buffer and shifts its predicted direction into the
// speculative history. Branches resolve oldest-first. A correct resolve
// retires the oldest checkpoint. A mispredict rebuilds the history from that
// checkpoint plus the actual direction, and flushes every in-flight checkpoint.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   spec_valid          a conditional branch was predicted this cycle
//   spec_taken          predicted direction (1 = taken)
//   spec_ready          push is accepted this cycle (combinational)
//   ckpt_id             slot that the branch pushed this cycle is assigned to
//   resolve_valid       the oldest in-flight branch resolves this cycle
//   resolve_mispredict  the resolved direction differs from the prediction
//   resolve_taken       actual direction of the resolved branch
//   history             speculative global history, bit 0 = newest outcome
//   count               number of in-flight checkpoints
//   full / empty        count == DEPTH / count == 0
module ghr_ckpt #(
    parameter int unsigned HIST_W = 10,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spec_valid,
    input  logic              spec_taken,
    output logic              spec_ready,
    output logic [IDX_W-1:0]  ckpt_id,
    input  logic              resolve_valid,
    input  logic              resolve_mispredict,
    input  logic              resolve_taken,
    output logic [HIST_W-1:0] history,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [HIST_W-1:0] buf_q [DEPTH];
    logic [HIST_W-1:0] history_q, history_d;
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic resolve_act;
    logic mispredict;
    logic retire;
    logic push;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A resolve with nothing in flight is ignored entirely.
    assign resolve_act = resolve_valid && !empty;
    assign mispredict  = resolve_act && resolve_mispredict;
    assign retire      = resolve_act && !resolve_mispredict;

    // No bypass: a retire in the same cycle does not free a slot for a push.
    assign spec_ready = !full && !mispredict;
    assign push       = spec_valid && spec_ready;

    assign ckpt_id = tail_q;
    assign history = history_q;
    assign count   = count_q;

    always_comb begin
        history_d = history_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (mispredict) begin
            history_d = {buf_q[head_q][HIST_W-2:0], resolve_taken};
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            if (push) begin
                history_d = {history_q[HIST_W-2:0], spec_taken};
                tail_d    = tail_q + IDX_W'(1);
            end
            if (retire) begin
                head_d = head_q + IDX_W'(1);
            end
            unique case ({push, retire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            history_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            history_q <= history_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Snapshot storage needs no reset; slots are only read after being written.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_q[tail_q] <= history_q;
        end
    end

endmodule

// File: tb/tb_ghr_ckpt.sv
module tb_ghr_ckpt;

    logic       clk = 1'b0;
    logic       reset;
    logic       spec_valid, spec_taken, spec_ready;
    logic [1:0] ckpt_id;
    logic       resolve_valid, resolve_mispredict, resolve_taken;
    logic [9:0] history;
    logic [2:0] count;
    logic       full, empty;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: history value, in-flight snapshot queue, tail slot.
    logic [9:0] m_hist;
    logic [9:0] m_q[$];
    int         m_tail;

    ghr_ckpt #(.HIST_W(10), .DEPTH(4), .IDX_W(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .spec_valid         (spec_valid),
        .spec_taken         (spec_taken),
        .spec_ready         (spec_ready),
        .ckpt_id            (ckpt_id),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .resolve_taken      (resolve_taken),
        .history            (history),
        .count              (count),
        .full               (full),
        .empty              (empty)
    );

    always #5 clk = ~clk;

    // Drive inputs shortly after a falling edge and let them settle.
    task automatic apply(input logic sv, input logic st, input logic rv, input logic rm,
                         input logic rt, input logic rs);
        spec_valid         = sv;
        spec_taken         = st;
        resolve_valid      = rv;
        resolve_mispredict = rm;
        resolve_taken      = rt;
        reset              = rs;
        #1;
    endtask

    // One rising edge, model update, then park at the falling edge.
    task automatic tick();
        logic       mis, rdy;
        logic [9:0] snap;
        @(posedge clk);
        if (reset) begin
            m_hist = '0;
            m_q.delete();
            m_tail = 0;
        end else begin
            mis = resolve_valid && resolve_mispredict && (m_q.size() != 0);
            rdy = (m_q.size() != 4) && !mis;
            if (mis) begin
                snap   = m_q[0];
                m_hist = {snap[8:0], resolve_taken};
                m_q.delete();
                m_tail = 0;
            end else begin
                if (resolve_valid && m_q.size() != 0) void'(m_q.pop_front());
                if (spec_valid && rdy) begin
                    m_q.push_back(m_hist);
                    m_hist = {m_hist[8:0], spec_taken};
                    m_tail = (m_tail + 1) % 4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (history !== 10'h000) begin n_err++; $display("FAIL reset_hist got %h want 000", history); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", empty, full); end
        n_vec++; if (ckpt_id !== 2'd0) begin n_err++; $display("FAIL reset_ckpt_id got %0d want 0", ckpt_id); end
        n_vec++; if (spec_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", spec_ready); end
    endtask

    task automatic test_push_mispredict();
        logic [2:0] dirs;
        dirs = 3'b011; // T, T, N in push order (bit i = push i)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, dirs[i], 1'b0, 1'b0, 1'b0, 1'b0);
            n_vec++; if (ckpt_id !== 2'(i)) begin n_err++; $display("FAIL push_ckpt_id[%0d] got %0d want %0d", i, ckpt_id, i); end
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (history !== 10'h006) begin n_err++; $display("FAIL push3_hist got %h want 006", history); end
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL push3_count got %0d want 3", count); end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++; if (spec_ready !== 1'b0) begin n_err++; $display("FAIL mis_ready got %b want 0", spec_ready); end
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (history !== 10'h001) begin n_err++; $display("FAIL mis_hist got %h want 001", history); end
        n_vec++; if (count !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL mis_flush got c=%0d e=%b want c=0 e=1", count, empty); end
        n_vec++; if (ckpt_id !== 2'd0) begin n_err++; $display("FAIL mis_tail got %0d want 0", ckpt_id); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", full); end
        n_vec++; if (spec_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", spec_ready); end
        tick();
        n_vec++; if (history !== 10'h00F) begin n_err++; $display("FAIL full_hist got %h want 00f", history); end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", count); end
        // Correct resolve while full must not let a push through.
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (spec_ready !== 1'b0) begin n_err++; $display("FAIL nobypass_ready got %b want 0", spec_ready); end
        tick();
        n_vec++; if (count !== 3'd3 || history !== 10'h00F) begin n_err++; $display("FAIL nobypass got c=%0d h=%h want c=3 h=00f", count, history); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL wrap_retire_count got %0d want 2", count); end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n_vec++; if (ckpt_id !== 2'(i)) begin n_err++; $display("FAIL wrap_ckpt_id[%0d] got %0d want %0d", i, ckpt_id, i); end
            tick();
        end
        n_vec++; if (count !== 3'd4 || full !== 1'b1) begin n_err++; $display("FAIL wrap_full got c=%0d f=%b want c=4 f=1", count, full); end
        // Head is slot 2 holding 0x003; spec_valid here must be dropped.
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (history !== 10'h006) begin n_err++; $display("FAIL wrap_mis_hist got %h want 006", history); end
        n_vec++; if (count !== 3'd0 || ckpt_id !== 2'd0) begin n_err++; $display("FAIL wrap_mis_flush got c=%0d id=%0d want 0 0", count, ckpt_id); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if (spec_ready !== 1'b1) begin n_err++; $display("FAIL simul_ready got %b want 1", spec_ready); end
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL simul_count got %0d want 2", count); end
        n_vec++; if (history !== 10'h005) begin n_err++; $display("FAIL simul_hist got %h want 005", history); end
        // Flush to empty with a nonzero history, then resolve while empty.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++; if (spec_ready !== 1'b1) begin n_err++; $display("FAIL empty_res_ready got %b want 1", spec_ready); end
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (history !== 10'h003 || count !== 3'd0 || empty !== 1'b1) begin
            n_err++; $display("FAIL empty_res got h=%h c=%0d e=%b want h=003 c=0 e=1", history, count, empty);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (history !== 10'h000 || count !== 3'd0 || empty !== 1'b1) begin
            n_err++; $display("FAIL rst_mid got h=%h c=%0d e=%b want 000 0 1", history, count, empty);
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (history !== 10'h000 || count !== 3'd0) begin
            n_err++; $display("FAIL rst_mis got h=%h c=%0d want 000 0", history, count);
        end
    endtask

    task automatic test_random();
        logic       sv, st, rv, rm, rt, rs, exp_ready;
        logic [1:0] exp_id;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sv = ($urandom_range(0, 3) != 0);
            st = 1'($urandom);
            rv = ($urandom_range(0, 2) == 0);
            rm = ($urandom_range(0, 5) == 0);
            rt = 1'($urandom);
            rs = ($urandom_range(0, 60) == 0);
            apply(sv, st, rv, rm, rt, rs);
            exp_ready = (m_q.size() != 4) && !(rv && rm && m_q.size() != 0);
            exp_id    = 2'(m_tail);
            n_vec++; if (spec_ready !== exp_ready || ckpt_id !== exp_id) begin
                n_err++; $display("FAIL rnd_pre[%0d] got rdy=%b id=%0d want rdy=%b id=%0d", i, spec_ready, ckpt_id, exp_ready, exp_id);
            end
            tick();
            n_vec++; if (history !== m_hist || count !== 3'(m_q.size())
                         || full !== (m_q.size() == 4) || empty !== (m_q.size() == 0)) begin
                n_err++; $display("FAIL rnd_post[%0d] got h=%h c=%0d f=%b e=%b want h=%h c=%0d", i, history, count, full, empty, m_hist, m_q.size());
            end
        end
    endtask

    initial begin
        m_hist = '0;
        m_tail = 0;
        @(negedge clk);
        test_reset();
        test_push_mispredict();
        test_full();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
